// File: rtl/if_imem_loader_if.sv
// ---------------------------------------------------------------------------
// if_imem_loader_if
// Host-link byte stream, instruction-memory write port and loader status
// signals for if_imem_loader, bundled as one interface.
//   slave  : the loader (receives the stream and Load_Start, drives memory writes and status)
//   master : the host/testbench side
// Signals:
//   Load_Start      frame-start pulse          (master -> slave)
//   Byte_In[7:0]    stream byte                (master -> slave)
//   Byte_Valid      Byte_In valid              (master -> slave)
//   Byte_Ready      loader accepts a byte      (slave -> master)
//   IMem_Write_En   one-cycle write strobe     (slave -> master)
//   IMem_Write_Addr word address               (slave -> master)
//   IMem_Write_Data 32-bit word                (slave -> master)
//   Core_Hold       stall core while loading   (slave -> master)
//   Load_Done       frame completed (level)    (slave -> master)
//   Load_Error      frame rejected (level)     (slave -> master)
//   Words_Loaded    words written this frame   (slave -> master)
// ---------------------------------------------------------------------------
interface if_imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  Load_Start;
    logic [7:0]            Byte_In;
    logic                  Byte_Valid;
    logic                  Byte_Ready;
    logic                  IMem_Write_En;
    logic [ADDR_WIDTH-1:0] IMem_Write_Addr;
    logic [31:0]           IMem_Write_Data;
    logic                  Core_Hold;
    logic                  Load_Done;
    logic                  Load_Error;
    logic [15:0]           Words_Loaded;

    modport master (
        output Load_Start, Byte_In, Byte_Valid,
        input  Byte_Ready, IMem_Write_En, IMem_Write_Addr, IMem_Write_Data,
        input  Core_Hold, Load_Done, Load_Error, Words_Loaded
    );

    modport slave (
        input  Load_Start, Byte_In, Byte_Valid,
        output Byte_Ready, IMem_Write_En, IMem_Write_Addr, IMem_Write_Data,
        output Core_Hold, Load_Done, Load_Error, Words_Loaded
    );
endinterface

// File: rtl/if_imem_loader.sv
// ---------------------------------------------------------------------------
// if_imem_loader
// Assembles a host byte stream into 32-bit words and writes them into the
// IF-stage instruction memory, holding the core while an image loads.
// Frame: 16-bit word count (big-endian), then count x 4 data bytes
// (big-endian per word).
// Ports:
//   Clk      rising-edge clock
//   Reset_n  asynchronous active-low reset
//   bus      if_imem_loader_if.slave (stream in, memory write port, status)
// Optional build macro IMEM_LOADER_CHECKSUM_EN: a trailing byte equal to the
// XOR of all data bytes is expected after the last word; mismatch -> error.
// All outputs are registered.
// ---------------------------------------------------------------------------
module if_imem_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned MAX_WORDS  = 1024
) (
    input logic             Clk,
    input logic             Reset_n,
    if_imem_loader_if.slave bus
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT_HI,
        S_COUNT_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        S_CHECK
`endif
    } state_e;

    // State entered once the last word (or a zero count) has been handled
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e S_END = S_CHECK;
`else
    localparam state_e S_END = S_DONE;
`endif

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       word_idx_q, word_idx_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [23:0]            shift_q, shift_d;
    logic                   ready_q, ready_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]      wr_data_q, wr_data_d;
    logic                   hold_q, hold_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]             xor_q, xor_d;
`endif

    logic                   xfer;
    logic [CNT_W-1:0]       full_cnt;
    logic [CNT_W-1:0]       word_inc;

    assign xfer     = bus.Byte_Valid && ready_q;
    assign full_cnt = {count_q[15:8], bus.Byte_In};
    assign word_inc = word_idx_q + 16'd1;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d      = xor_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.Load_Start) begin
                    state_d    = S_COUNT_HI;
                    word_idx_d = '0;
                    byte_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d      = '0;
`endif
                end
            end
            S_COUNT_HI: begin
                if (xfer) begin
                    count_d[15:8] = bus.Byte_In;
                    state_d       = S_COUNT_LO;
                end
            end
            S_COUNT_LO: begin
                if (xfer) begin
                    count_d = full_cnt;
                    if (32'(full_cnt) > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if (full_cnt == '0) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    shift_d    = {shift_q[15:0], bus.Byte_In};
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d      = xor_q ^ bus.Byte_In;
`endif
                    // Fourth byte completes the word: capture it for the write cycle
                    if (byte_idx_q == 2'd3) begin
                        state_d   = S_WRITE;
                        wr_addr_d = ADDR_WIDTH'(BASE_ADDR + 32'(word_idx_q));
                        wr_data_d = {shift_q, bus.Byte_In};
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_inc;
                state_d    = (word_inc == count_q) ? S_END : S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    state_d = (bus.Byte_In == xor_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the state being entered
        wr_en_d = (state_d == S_WRITE);
        hold_d  = (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERROR);
`ifdef IMEM_LOADER_CHECKSUM_EN
        ready_d = state_d inside {S_COUNT_HI, S_COUNT_LO, S_DATA, S_CHECK};
`else
        ready_d = state_d inside {S_COUNT_HI, S_COUNT_LO, S_DATA};
`endif
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            ready_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            ready_q    <= ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    assign bus.Byte_Ready      = ready_q;
    assign bus.IMem_Write_En   = wr_en_q;
    assign bus.IMem_Write_Addr = wr_addr_q;
    assign bus.IMem_Write_Data = wr_data_q;
    assign bus.Core_Hold       = hold_q;
    assign bus.Load_Done       = done_q;
    assign bus.Load_Error      = err_q;
    assign bus.Words_Loaded    = word_idx_q;

endmodule
